hart_scheduler: RTL and testbench

Barrel-style issue scheduler for the multi-hart core pipeline. Each cycle it picks at most one runnable hart, round-robin, and issues its ID into the front of the pipeline. It tracks every issued ID through a fixed-depth retire delay line, so a hart is never in the pipeline twice. Per-hart enable and block/wake inputs let the front end park harts that are waiting on long-latency memory.

---
 rtl/hart_scheduler_pkg.sv | 17 +
 rtl/hart_scheduler_if.sv | 47 ++++
 rtl/hart_scheduler_delay_line.sv | 32 +++
 rtl/hart_scheduler.sv | 145 ++++++++++++++
 tb/tb_hart_scheduler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/hart_scheduler_pkg.sv
// Shared constants and slot type for the barrel issue scheduler.
// Imported by the interface, delay line and scheduler top.
package hart_sched_pkg;

  localparam int DEF_NUM_HARTS  = 16;
  localparam int DEF_PIPE_DEPTH = 15;

  // Hart field is sized for the largest supported barrel; narrower
  // configurations zero-extend into it.
  localparam int SLOT_HART_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_HART_W-1:0] hart;
  } sched_slot_t;

endpackage

// File: rtl/hart_scheduler_if.sv
// Front-end <-> scheduler bundle: enables, park/unpark pulses,
// issue and retire streams, in-flight mask.
interface hart_scheduler_if
  import hart_sched_pkg::*;
#(
  parameter int NUM_HARTS = DEF_NUM_HARTS,
  parameter int HART_W    = $clog2(NUM_HARTS)
);

  logic [NUM_HARTS-1:0] i_hart_enable;
  logic                 i_block_valid;
  logic [HART_W-1:0]    i_block_hart;
  logic                 i_wake_valid;
  logic [HART_W-1:0]    i_wake_hart;
  logic                 o_issue_valid;
  logic [HART_W-1:0]    o_issue_hart;
  logic                 o_retire_valid;
  logic [HART_W-1:0]    o_retire_hart;
  logic [NUM_HARTS-1:0] o_inflight;

  modport master (
    output i_hart_enable,
    output i_block_valid,
    output i_block_hart,
    output i_wake_valid,
    output i_wake_hart,
    input  o_issue_valid,
    input  o_issue_hart,
    input  o_retire_valid,
    input  o_retire_hart,
    input  o_inflight
  );

  modport slave (
    input  i_hart_enable,
    input  i_block_valid,
    input  i_block_hart,
    input  i_wake_valid,
    input  i_wake_hart,
    output o_issue_valid,
    output o_issue_hart,
    output o_retire_valid,
    output o_retire_hart,
    output o_inflight
  );

endinterface

// File: rtl/hart_scheduler_delay_line.sv
// Fixed-depth shift register of issue slots; its tail is the
// retire stream. Every stage clears on reset.
module hart_delay_line
  import hart_sched_pkg::*;
#(
  parameter int DEPTH = DEF_PIPE_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  sched_slot_t din,
  output sched_slot_t dout
);

  sched_slot_t stage [DEPTH];

  // Shift one stage per cycle; reset drops every pending slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/hart_scheduler.sv
// Barrel issue scheduler: round-robin pick of one runnable hart per
// cycle, with in-flight tracking so a hart is never issued twice.
module hart_scheduler
  import hart_sched_pkg::*;
#(
  parameter int NUM_HARTS  = DEF_NUM_HARTS,
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int HART_W     = $clog2(NUM_HARTS)
) (
  input logic             clk,
  input logic             reset,
  hart_scheduler_if.slave bus
);

  logic [NUM_HARTS-1:0] blocked;
  logic [NUM_HARTS-1:0] blocked_nxt;
  logic [NUM_HARTS-1:0] inflight;
  logic [NUM_HARTS-1:0] elig;
  logic [NUM_HARTS-1:0] retire_mask;
  logic [NUM_HARTS-1:0] grant_mask;
  logic [HART_W-1:0]    last;
  logic [HART_W-1:0]    issue_hart;
  logic [HART_W-1:0]    grant_hart;
  logic [HART_W-1:0]    retire_hart;
  logic                 issue_valid;
  logic                 grant_valid;
  logic [HART_W:0]      pick;
  sched_slot_t          issue_slot;
  sched_slot_t          retire_slot;
  logic                 unused_slot_hi;

  // Rotate so ptr+1 sits at bit 0, take the lowest set bit, rotate
  // back. Returns {found, hart}.
  function automatic logic [HART_W:0] rr_pick(
    input logic [NUM_HARTS-1:0] req,
    input logic [HART_W-1:0]    ptr
  );
    logic [HART_W-1:0]      start;
    logic [2*NUM_HARTS-1:0] dbl;
    logic [NUM_HARTS-1:0]   rot;
    logic [HART_W-1:0]      off;
    start = ptr + HART_W'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_HARTS-1:0];
    off   = '0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = HART_W'(i);
      end
    end
    return {|rot, start + off};
  endfunction

  assign retire_hart = HART_W'(retire_slot.hart);

  // Upper slot bits are always zero for this configuration.
  assign unused_slot_hi = |(retire_slot.hart >> HART_W);

  // One-hot of the hart leaving the pipe this cycle.
  always_comb begin
    retire_mask = '0;
    if (retire_slot.valid) begin
      retire_mask[retire_hart] = 1'b1;
    end
  end

  // A retiring hart counts as free so it can reissue immediately.
  assign elig = bus.i_hart_enable & ~blocked
              & (~inflight | retire_mask);

  assign pick        = rr_pick(elig, last);
  assign grant_valid = pick[HART_W];
  assign grant_hart  = pick[HART_W-1:0];

  // One-hot of the hart granted this cycle.
  always_comb begin
    grant_mask = '0;
    if (grant_valid) begin
      grant_mask[grant_hart] = 1'b1;
    end
  end

  // Park/unpark update; wake is applied last so it wins a collision.
  always_comb begin
    blocked_nxt = blocked;
    if (bus.i_block_valid) begin
      blocked_nxt[bus.i_block_hart] = 1'b1;
    end
    if (bus.i_wake_valid) begin
      blocked_nxt[bus.i_wake_hart] = 1'b0;
    end
  end

  // Issue register and round-robin pointer; idle cycles hold both.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_hart  <= '0;
      last        <= HART_W'(NUM_HARTS - 1);
    end else begin
      issue_valid <= grant_valid;
      if (grant_valid) begin
        issue_hart <= grant_hart;
        last       <= grant_hart;
      end
    end
  end

  // In-flight mask: set on issue beats clear on retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      inflight <= (inflight & ~retire_mask) | grant_mask;
    end
  end

  // Parked-hart mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      blocked <= '0;
    end else begin
      blocked <= blocked_nxt;
    end
  end

  assign issue_slot.valid = issue_valid;
  assign issue_slot.hart  = SLOT_HART_W'(issue_hart);

  hart_delay_line #(
    .DEPTH (PIPE_DEPTH)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (issue_slot),
    .dout  (retire_slot)
  );

  assign bus.o_issue_valid  = issue_valid;
  assign bus.o_issue_hart   = issue_hart;
  assign bus.o_retire_valid = retire_slot.valid;
  assign bus.o_retire_hart  = retire_hart;
  assign bus.o_inflight     = inflight;

endmodule

// File: tb/tb_hart_scheduler.sv
// Directed bench for hart_scheduler at default 16 harts / depth 15.
// Cycle 0 is the first cycle after reset release.
module tb_hart_scheduler;

  localparam int NH = 16;
  localparam int PD = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc;
  int   vectors;
  int   miscompares;

  hart_scheduler_if #(.NUM_HARTS(NH)) bus ();

  hart_scheduler #(
    .NUM_HARTS  (NH),
    .PIPE_DEPTH (PD)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc %0d: got %0h want %0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulses_off();
    bus.i_block_valid = 1'b0;
    bus.i_wake_valid  = 1'b0;
  endtask

  task automatic reset_dut(input logic [NH-1:0] en);
    reset             = 1'b1;
    bus.i_hart_enable = en;
    bus.i_block_hart  = '0;
    bus.i_wake_hart   = '0;
    pulses_off();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic chk_issue(input string tag, input logic v,
                           input int h);
    chk({tag, "_v"}, 32'(bus.o_issue_valid), 32'(v));
    chk({tag, "_h"}, 32'(bus.o_issue_hart), 32'(h));
  endtask

  task automatic chk_retire(input string tag, input int h);
    chk({tag, "_rv"}, 32'(bus.o_retire_valid), 32'd1);
    chk({tag, "_rh"}, 32'(bus.o_retire_hart), 32'(h));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;

    // Full barrel
    reset_dut('1);
    chk_issue("rst", 1'b0, 0);
    chk("rst_rv", 32'(bus.o_retire_valid), 32'd0);
    chk("rst_rh", 32'(bus.o_retire_hart), 32'd0);
    chk("rst_inf", 32'(bus.o_inflight), 32'd0);
    for (int c = 1; c <= 40; c++) begin
      tick();
      chk_issue("bar", 1'b1, (c - 1) % NH);
      chk("bar_rv", 32'(bus.o_retire_valid), 32'(c >= 16));
      if (c >= 16) chk("bar_rh", 32'(bus.o_retire_hart), (c - 16) % NH);
      chk("bar_inf", 32'(bus.o_inflight),
          (c >= 16) ? 32'hffff : (32'd1 << c) - 32'd1);
    end

    // Mid-run reset
    reset_dut('1);
    run_to(10);
    reset = 1'b1;
    tick();
    chk_issue("mrst", 1'b0, 0);
    chk("mrst_rv", 32'(bus.o_retire_valid), 32'd0);
    chk("mrst_rh", 32'(bus.o_retire_hart), 32'd0);
    chk("mrst_inf", 32'(bus.o_inflight), 32'd0);
    reset = 1'b0;
    for (int c = 12; c <= 30; c++) begin
      tick();
      chk_issue("mrun", 1'b1, (c - 12) % NH);
      chk("mrun_rv", 32'(bus.o_retire_valid), 32'(c >= 27));
      if (c >= 27) chk("mrun_rh", 32'(bus.o_retire_hart), c - 27);
    end

    // Sparse enable: harts 3 and 9
    reset_dut(16'h0208);
    for (int c = 1; c <= 18; c++) begin
      tick();
      chk_issue("sp", (c == 1 || c == 2 || c == 17 || c == 18),
                (c == 1 || c == 17) ? 3 : 9);
      chk("sp_rv", 32'(bus.o_retire_valid), 32'(c == 16 || c == 17));
      if (c == 16) chk("sp_rh", 32'(bus.o_retire_hart), 32'd3);
      if (c == 17) chk("sp_rh", 32'(bus.o_retire_hart), 32'd9);
      if (c == 5) chk("sp_inf", 32'(bus.o_inflight), 32'h0208);
    end

    // Block hart 5 while in flight, wake it at cycle 40
    reset_dut('1);
    run_to(8);
    bus.i_block_valid = 1'b1;
    bus.i_block_hart  = 4'd5;
    tick();
    pulses_off();
    run_to(21);
    chk_issue("bw21", 1'b1, 4);
    chk_retire("bw21", 5);
    tick();
    chk_issue("bw22", 1'b0, 4);
    tick();
    chk_issue("bw23", 1'b1, 6);
    for (int c = 24; c <= 53; c++) begin
      tick();
      chk("bw_no5", 32'(bus.o_issue_valid && bus.o_issue_hart == 4'd5),
          32'd0);
      if (c == 25) chk("bw_inf5", 32'(bus.o_inflight[5]), 32'd0);
      if (c == 40) begin
        bus.i_wake_valid = 1'b1;
        bus.i_wake_hart  = 4'd5;
      end
      if (c == 41) pulses_off();
    end
    tick();
    chk_issue("bw54", 1'b1, 5);
    tick();
    chk_issue("bw55", 1'b1, 6);

    // Block/wake collisions with harts 2 and 7 enabled
    reset_dut(16'h0084);
    run_to(3);
    bus.i_block_valid = 1'b1;
    bus.i_block_hart  = 4'd2;
    bus.i_wake_valid  = 1'b1;
    bus.i_wake_hart   = 4'd2;
    tick();
    pulses_off();
    bus.i_block_valid = 1'b1;
    bus.i_block_hart  = 4'd7;
    tick();
    pulses_off();
    run_to(17);
    chk_issue("col17", 1'b1, 2);
    bus.i_block_valid = 1'b1;
    bus.i_block_hart  = 4'd2;
    bus.i_wake_valid  = 1'b1;
    bus.i_wake_hart   = 4'd7;
    tick();
    pulses_off();
    chk("col18_v", 32'(bus.o_issue_valid), 32'd0);
    tick();
    chk_issue("col19", 1'b1, 7);
    run_to(32);
    chk_retire("col32", 2);
    tick();
    chk("col33_v", 32'(bus.o_issue_valid), 32'd0);
    tick();
    chk("col34_v", 32'(bus.o_issue_valid), 32'd0);
    chk_retire("col34", 7);
    tick();
    chk_issue("col35", 1'b1, 7);

    // Disable hart 4 while in flight, re-enable at cycle 25
    reset_dut('1);
    run_to(5);
    chk_issue("dis5", 1'b1, 4);
    tick();
    bus.i_hart_enable[4] = 1'b0;
    run_to(20);
    chk_retire("dis20", 4);
    tick();
    chk("dis21_v", 32'(bus.o_issue_valid), 32'd0);
    tick();
    chk_issue("dis22", 1'b1, 5);
    chk("dis_inf4", 32'(bus.o_inflight[4]), 32'd0);
    for (int c = 23; c <= 36; c++) begin
      tick();
      chk("dis_no4", 32'(bus.o_issue_valid && bus.o_issue_hart == 4'd4),
          32'd0);
      if (c == 25) bus.i_hart_enable[4] = 1'b1;
    end
    tick();
    chk_issue("dis37", 1'b1, 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
